// File: rtl/comp_pkg.sv
// Shared types and constants for the byte-serial word comparator.
package comp_pkg;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/comp_8.sv
// Combinational 8-bit magnitude compare stage with EQ/GT cascade inputs.
module comp_8
  import comp_pkg::*;
(
  input  logic [BYTE_W-1:0] i_a,
  input  logic [BYTE_W-1:0] i_b,
  input  logic              i_eq1,
  input  logic              i_gt1,
  output logic              o_eq,
  output logic              o_gt
);
  // Higher-order bytes dominate: this byte only matters while everything above was equal.
  assign o_eq = i_eq1 & (i_a == i_b);
  assign o_gt = i_gt1 | (i_eq1 & (i_a > i_b));
endmodule

// File: rtl/comp_serial_word.sv
// Byte-serial unsigned word comparator, MSB byte first, one verdict per word.
module comp_serial_word
  import comp_pkg::*;
#(
  parameter int NBYTES = 4,
  parameter int CW     = $clog2(NBYTES) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BYTE_W-1:0] a_byte,
  input  logic [BYTE_W-1:0] b_byte,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              eq,
  output logic              gt,
  output logic              lt,
  output logic              busy
);
  localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_eq;
  logic          r_gt;
  logic          w_eq;
  logic          w_gt;
  logic          w_done;

  comp_8 u_cmp (
    .i_a   (a_byte),
    .i_b   (b_byte),
    .i_eq1 (r_eq),
    .i_gt1 (r_gt),
    .o_eq  (w_eq),
    .o_gt  (w_gt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_eq    <= 1'b1;
      r_gt    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_state <= RUN;
          r_cnt   <= '0;
          r_eq    <= 1'b1;
          r_gt    <= 1'b0;
        end
        // A restart wins over a same-cycle beat; that beat is handshaken but dropped.
        RUN: if (start) begin
          r_cnt <= '0;
          r_eq  <= 1'b1;
          r_gt  <= 1'b0;
        end else if (in_valid) begin
          r_eq  <= w_eq;
          r_gt  <= w_gt;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) r_state <= DONE;
        end
        DONE: if (res_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_done    = (r_state == DONE);
  assign in_ready  = (r_state == RUN);
  assign res_valid = w_done;
  assign busy      = (r_state != IDLE);
  assign eq        = w_done & r_eq;
  assign gt        = w_done & r_gt;
  assign lt        = w_done & ~r_eq & ~r_gt;
endmodule

// File: tb/tb_comp_serial_word.sv
// Randomized and directed bench for comp_serial_word against an integer-compare model.
module tb_comp_serial_word;
  localparam int NB = 4;

  logic       clk = 1'b0;
  logic       rst_n, start, in_valid, res_ready;
  logic [7:0] a_byte, b_byte;
  logic       in_ready, res_valid, eq, gt, lt, busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  comp_serial_word #(.NBYTES(NB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_byte    (a_byte),
    .b_byte    (b_byte),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .eq        (eq),
    .gt        (gt),
    .lt        (lt),
    .busy      (busy)
  );

  // Reference: whole-word unsigned compare, result as {eq,gt,lt}.
  function automatic logic [2:0] model(input logic [31:0] a, input logic [31:0] b);
    if (a == b)     return 3'b100;
    else if (a > b) return 3'b010;
    else            return 3'b001;
  endfunction

  function automatic logic [7:0] byte_of(input logic [31:0] w, input int i);
    return w[31 - 8*i -: 8];
  endfunction

  // Inputs change at negedge; one tick = one rising edge, back at the next negedge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input logic [7:0] a, input logic [7:0] b);
    in_valid = 1'b1;
    a_byte   = a;
    b_byte   = b;
    tick();
    in_valid = 1'b0;
    a_byte   = $urandom;
    b_byte   = $urandom;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
    a_byte = 8'h00; b_byte = 8'h00;
    #3;
    n_vec++;
    if ({in_ready, res_valid, eq, gt, lt, busy} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_outputs got=%b want=000000", {in_ready, res_valid, eq, gt, lt, busy});
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_vec++;
    if ({in_ready, res_valid, busy} !== 3'b000) begin
      n_err++;
      $display("FAIL idle_after_reset got=%b want=000", {in_ready, res_valid, busy});
    end
  endtask

  task automatic test_equal();
    logic [31:0] a = 32'h12345678;
    res_ready = 1'b1;
    do_start();
    n_vec++;
    if ({in_ready, busy} !== 2'b11) begin
      n_err++;
      $display("FAIL run_entry got=%b want=11", {in_ready, busy});
    end
    for (int i = 0; i < NB; i++) beat(byte_of(a, i), byte_of(a, i));
    n_vec++;
    if ({res_valid, eq, gt, lt} !== 4'b1100) begin
      n_err++;
      $display("FAIL equal_verdict got=%b want=1100", {res_valid, eq, gt, lt});
    end
    tick();
    n_vec++;
    if ({res_valid, busy, eq} !== 3'b000) begin
      n_err++;
      $display("FAIL equal_one_cycle got=%b want=000", {res_valid, busy, eq});
    end
  endtask

  task automatic test_gt_full_consume();
    logic [31:0] a = 32'h80000000;
    logic [31:0] b = 32'h7FFFFFFF;
    res_ready = 1'b0;
    do_start();
    for (int i = 0; i < NB; i++) begin
      n_vec++;
      if (in_ready !== 1'b1 || res_valid !== 1'b0) begin
        n_err++;
        $display("FAIL gt_consume_beat%0d in_ready=%b res_valid=%b want=1,0", i, in_ready, res_valid);
      end
      beat(byte_of(a, i), byte_of(b, i));
    end
    n_vec++;
    if ({in_ready, res_valid, eq, gt, lt} !== {2'b01, model(a, b)}) begin
      n_err++;
      $display("FAIL gt_verdict got=%b want=%b", {in_ready, res_valid, eq, gt, lt}, {2'b01, model(a, b)});
    end
    res_ready = 1'b1;
    tick();
  endtask

  task automatic test_gaps();
    logic [31:0] a = 32'h000000FE;
    logic [31:0] b = 32'h000000FF;
    res_ready = 1'b0;
    do_start();
    for (int i = 0; i < NB; i++) begin
      beat(byte_of(a, i), byte_of(b, i));
      if (i < NB - 1) begin
        for (int g = 0; g < 2; g++) begin
          n_vec++;
          if ({in_ready, res_valid} !== 2'b10) begin
            n_err++;
            $display("FAIL gap_b%0d_c%0d got=%b want=10", i, g, {in_ready, res_valid});
          end
          tick();
        end
      end
    end
    n_vec++;
    if ({res_valid, eq, gt, lt} !== {1'b1, model(a, b)}) begin
      n_err++;
      $display("FAIL gap_verdict got=%b want=%b", {res_valid, eq, gt, lt}, {1'b1, model(a, b)});
    end
    res_ready = 1'b1;
    tick();
  endtask

  task automatic test_restart();
    logic [31:0] a = 32'h01020304;
    logic [31:0] b = 32'h01020305;
    res_ready = 1'b0;
    do_start();
    beat(8'hFF, 8'h00);
    beat(8'hFF, 8'h00);
    // Restart with a live beat in the same cycle: that beat must not count.
    start = 1'b1; in_valid = 1'b1; a_byte = 8'hFF; b_byte = 8'h00;
    tick();
    start = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if (i == NB - 1) begin
        n_vec++;
        if ({in_ready, res_valid} !== 2'b10) begin
          n_err++;
          $display("FAIL restart_count got=%b want=10", {in_ready, res_valid});
        end
      end
      beat(byte_of(a, i), byte_of(b, i));
    end
    n_vec++;
    if ({res_valid, eq, gt, lt} !== {1'b1, model(a, b)}) begin
      n_err++;
      $display("FAIL restart_verdict got=%b want=%b", {res_valid, eq, gt, lt}, {1'b1, model(a, b)});
    end
    res_ready = 1'b1;
    tick();
  endtask

  task automatic test_backpressure();
    logic [31:0] a = 32'h00000010;
    logic [31:0] b = 32'h00000020;
    res_ready = 1'b0;
    do_start();
    for (int i = 0; i < NB; i++) beat(byte_of(a, i), byte_of(b, i));
    for (int c = 0; c < 5; c++) begin
      n_vec++;
      if ({res_valid, busy, in_ready, eq, gt, lt} !== {3'b110, model(a, b)}) begin
        n_err++;
        $display("FAIL hold_c%0d got=%b want=%b", c, {res_valid, busy, in_ready, eq, gt, lt}, {3'b110, model(a, b)});
      end
      start = (c == 2); // start while DONE is ignored
      tick();
      start = 1'b0;
    end
    res_ready = 1'b1;
    tick();
    n_vec++;
    if ({res_valid, busy, lt} !== 3'b000) begin
      n_err++;
      $display("FAIL hold_release got=%b want=000", {res_valid, busy, lt});
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] a = 32'hA5A5A5A5;
    res_ready = 1'b1;
    do_start();
    beat(byte_of(a, 0), 8'h00);
    beat(byte_of(a, 1), 8'h00);
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({in_ready, res_valid, eq, gt, lt, busy} !== 6'b0) begin
      n_err++;
      $display("FAIL async_reset got=%b want=000000", {in_ready, res_valid, eq, gt, lt, busy});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      beat($urandom, $urandom);
      n_vec++;
      if ({res_valid, busy} !== 2'b00) begin
        n_err++;
        $display("FAIL post_reset_c%0d got=%b want=00", i, {res_valid, busy});
      end
    end
    do_start();
    for (int i = 0; i < NB; i++) beat(byte_of(a, i), 8'h00);
    n_vec++;
    if ({res_valid, eq, gt, lt} !== {1'b1, model(a, 32'h0)}) begin
      n_err++;
      $display("FAIL post_reset_word got=%b want=%b", {res_valid, eq, gt, lt}, {1'b1, model(a, 32'h0)});
    end
    tick();
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    int k;
    for (int w = 0; w < 24; w++) begin
      a = $urandom;
      case ($urandom_range(0, 2))
        0: b = a;
        1: begin
          k = $urandom_range(0, NB - 1);
          b = a ^ (32'($urandom_range(1, 255)) << (8 * k));
        end
        default: b = $urandom;
      endcase
      res_ready = 1'b0;
      do_start();
      for (int i = 0; i < NB; i++) begin
        repeat ($urandom_range(0, 2)) tick();
        n_vec++;
        if ({in_ready, res_valid} !== 2'b10) begin
          n_err++;
          $display("FAIL rand_w%0d_b%0d got=%b want=10", w, i, {in_ready, res_valid});
        end
        beat(byte_of(a, i), byte_of(b, i));
      end
      repeat ($urandom_range(0, 3)) tick();
      n_vec++;
      if ({res_valid, eq, gt, lt} !== {1'b1, model(a, b)}) begin
        n_err++;
        $display("FAIL rand_w%0d a=%h b=%h got=%b want=%b", w, a, b, {res_valid, eq, gt, lt}, {1'b1, model(a, b)});
      end
      res_ready = 1'b1;
      tick();
      n_vec++;
      if ({res_valid, busy} !== 2'b00) begin
        n_err++;
        $display("FAIL rand_w%0d_release got=%b want=00", w, {res_valid, busy});
      end
    end
  endtask

  initial begin
    test_reset();
    test_equal();
    test_gt_full_consume();
    test_gaps();
    test_restart();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
